// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 receiver: deframes keyboard bytes and
// turns make/break sequences into key-held levels.
module ps2_key_decoder #(
  parameter logic [7:0] KEY1_CODE      = 8'h16,
  parameter logic [7:0] KEY2_CODE      = 8'h1E,
  parameter int         TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       iResetn,
  input  logic       iPS2Clk,
  input  logic       iPS2Dat,
  output logic       o1,
  output logic       o2,
  output logic [7:0] oScanCode,
  output logic       oScanValid,
  output logic       oFrameErr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_d;

  logic          clk_s1;
  logic          clk_s2;
  logic          clk_s3;
  logic          dat_s1;
  logic          dat_s2;
  logic          fall;
  logic          din;
  logic [2:0]    cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          tout;
  logic          good;
  logic          bad;
  logic          brk;
  logic          ext;

  assign fall = clk_s3 & ~clk_s2;
  assign din  = dat_s2;

  // A stalled PS/2 clock must not hold a partial frame forever.
  assign tout = (state != IDLE) && !fall &&
                (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronisers plus a third clock flop for edge detect.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= iPS2Clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= iPS2Dat;
      dat_s2 <= dat_s1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state logic and frame good/bad verdicts.
  always_comb begin
    state_d = state;
    good    = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall && !din) state_d = DATA;
      end
      DATA: begin
        if (fall && cnt == 3'd7) state_d = PARITY;
      end
      PARITY: begin
        if (fall) state_d = STOP;
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (din && (^{shift, par})) good = 1'b1;
          else                        bad  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tout) begin
      state_d = IDLE;
      bad     = 1'b1;
    end
  end

  // Inactivity counter, parked at zero while idle.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn)            tcnt <= '0;
    else if (state_d == IDLE) tcnt <= '0;
    else if (fall)           tcnt <= '0;
    else                     tcnt <= tcnt + TW'(1);
  end

  // Bit counter, shift register and parity capture.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      cnt   <= '0;
      shift <= '0;
      par   <= 1'b0;
    end else if (fall) begin
      unique case (state)
        IDLE:    cnt <= '0;
        DATA: begin
          shift[cnt] <= din;
          cnt        <= cnt + 3'd1;
        end
        PARITY:  par <= din;
        default: ;
      endcase
    end
  end

  // Byte output, error pulse and make/break decoding.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      oScanCode  <= '0;
      oScanValid <= 1'b0;
      oFrameErr  <= 1'b0;
      o1         <= 1'b0;
      o2         <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else begin
      oScanValid <= good;
      oFrameErr  <= bad;
      if (bad) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (good) begin
        oScanCode <= shift;
        if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!ext && shift == KEY1_CODE) o1 <= ~brk;
          if (!ext && shift == KEY2_CODE) o2 <= ~brk;
        end
      end
    end
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receive-only PS/2 keyboard front end that deframes scan-code set 2 bytes from the keyboard's clock/data lines and turns make/break sequences into level "key held" flags. It feeds the main menu controller's `i1`/`i2` inputs, which expect a level that is high while the key is down and low once it is released. It also exposes the raw byte stream for the game modes and for debug.

## Interface
- `KEY1_CODE`, default 8'h16: set-2 make code driving `o1` (main-row '1').
- `KEY2_CODE`, default 8'h1E: set-2 make code driving `o2` (main-row '2').
- `TIMEOUT_CYCLES`, default 10000: `clk` cycles without a PS/2 falling edge before a partial frame is abandoned (200 µs at 50 MHz).
- `clk`  in  1: system clock, 50 MHz. This is the only clock.
- `iResetn`  in  1: asynchronous, active-low reset.
- `iPS2Clk`  in  1: raw PS/2 clock pin, asynchronous to `clk`.
- `iPS2Dat`  in  1: raw PS/2 data pin, asynchronous to `clk`.
- `o1`  out  1: high while `KEY1_CODE` is held.
- `o2`  out  1: high while `KEY2_CODE` is held.
- `oScanCode`  out  8: last good received byte.
- `oScanValid`  out  1: one-cycle pulse when `oScanCode` updates.
- `oFrameErr`  out  1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Input synchronisation.** Each pin passes through 2 flops. A third flop on the clock line provides falling-edge detection: `fall` = previous synced clock high and current synced clock low. Data is sampled from the synced data line in the cycle `fall` is true.
- **Frame format.** 1 start bit (0), 8 data bits sent LSB first, odd parity, 1 stop bit (1).
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data 0, clear the bit counter and go to DATA. On `fall` with data 1 (bad start), stay in IDLE with no error pulse.
  - DATA: each `fall` shifts data into bit `[cnt]`. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is good if stop = 1 and XOR(data, parity) = 1. A good frame loads `oScanCode`, pulses `oScanValid` and runs the decoder. A bad frame pulses `oFrameErr` and discards the byte. Either way, return to IDLE.
- **Timeout.**
  - In any non-IDLE state, a counter counts cycles since the last `fall`. It resets on each `fall`.
  - When the count reaches `TIMEOUT_CYCLES`, pulse `oFrameErr`, go to IDLE and discard the partial byte.
  - The counter is held at 0 in IDLE.
- **Decoder** (runs on good bytes only). Two flags, `brk` and `ext`, are cleared by reset and by any `oFrameErr`.
  - Byte 8'hF0: set `brk`. No key change.
  - Byte 8'hE0: set `ext`. No key change.
  - Any other byte with `ext` set: ignore it (extended keys never alias onto `o1`/`o2`), then clear both flags.
  - Byte == `KEY1_CODE`: `o1` <= ~`brk`. Byte == `KEY2_CODE`: `o2` <= ~`brk`. Then clear both flags.
  - Any other byte: clear both flags. `o1`/`o2` are unchanged.
- **Typematic repeats** of a held key re-write 1, so the output stays high without glitching.
- **Simultaneous keys.** `o1` and `o2` are independent, so both can be high together.
- **Reset values:**
  - `o1`=0, `o2`=0.
  - `oScanCode`=8'h00, `oScanValid`=0, `oFrameErr`=0.
  - FSM in IDLE; counters, `brk` and `ext` all 0.
- **Reset mid-frame** discards the frame. The next start bit is decoded normally.

## Timing
- Edge 1 is the first rising `clk` edge that samples `iPS2Clk` low after its falling transition.
- `fall` is true after edge 2. The FSM/datapath registers update at edge 3.
- The `oScanValid`/`oFrameErr` pulse is high from edge 3 to edge 4 after the stop-bit falling edge. It is exactly one cycle.
- `o1`/`o2` change at the same edge that `oScanValid` rises.
- The timeout pulse rises `TIMEOUT_CYCLES` cycles after the last `fall` (±1 cycle).
- The PS/2 clock is 10–16.7 kHz, so the minimum spacing between `fall` events is about 3000 cycles. No back-to-back handling is required.
- There is no handshake: consumers sample `oScanValid` and must not back-pressure.

## Test plan
- **Press/release '1':** send frames 16, F0, 16. Require: `o1`=1 after byte 1; `o1`=0 after byte 3; 3 `oScanValid` pulses with `oScanCode` 16, F0, 16; `o2`=0 throughout.
- **Overlapping '1' and '2':** send 16, 1E, F0 16, F0 1E. Require: `o1`=`o2`=1 after 1E; `o1` falls at the first release while `o2` stays 1; `o2` falls at the end.
- **Parity error:** send 16 with even parity. Require: one `oFrameErr` pulse, no `oScanValid`, `o1` stays 0. Then send F0 (good), then 16 with a bad stop bit. Require: `oFrameErr` pulses, `brk` is cleared, and a following good 16 sets `o1`=1.
- **Timeout:** after 4 data bits, stop the clock. Require: `oFrameErr` pulses `TIMEOUT_CYCLES` cycles later. A following good 1E sets `o2`=1.
- **Extended key:** send E0 16 with `o1`=0. Require: `o1` stays 0, 2 `oScanValid` pulses. Send E0 F0 16 while `o1`=1. Require: `o1` stays 1.
- **Reset:** assert `iResetn`=0 mid-frame while `o1`=1. Require: all outputs 0 immediately (async). After release, a complete 1E frame sets `o2`=1 with the pulse latency above.
